// File: rtl/blk_data_mem_responder.sv
// rtl/blk_data_mem_responder.sv - data-memory responder: combinational word reads, byte-lane word writes,
// latency-timed 256-bit block reads/writes with one-cycle valid pulses.
module blk_data_mem_responder #(
    parameter int LINE_BITS   = 8,
    parameter int BLK_LATENCY = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  data_address_fCPU,
    input  logic         MemRead_fCPU,
    input  logic         MemWrite_fCPU,
    input  logic [31:0]  data_write_fCPU,
    input  logic [1:0]   data_write_size_fCPU,
    output logic [31:0]  data_read_2CPU,
    input  logic         dBlkRead_fCPU,
    input  logic         dBlkWrite_fCPU,
    input  logic [255:0] block_write_fCPU,
    output logic [255:0] block_read_2CPU,
    output logic         block_read_valid_2CPU,
    output logic         block_write_valid_2CPU,
    output logic         busy_2CPU
);

    localparam int WORDS = 1 << (LINE_BITS + 3);
    localparam logic [7:0] LAT_M1 = 8'(BLK_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic [LINE_BITS-1:0]   r_line;
    logic [255:0]           r_blk_wdata;
    logic [31:0]            r_mem [0:WORDS-1];

    logic [LINE_BITS-1:0]   w_line;
    logic [2:0]             w_word;
    logic [1:0]             w_off;
    logic [LINE_BITS+2:0]   w_widx;
    logic [31:0]            w_rd_word;
    logic [2:0]             w_nbytes;
    logic [31:0]            w_data_al;
    logic [3:0]             w_bmask;
    logic [31:0]            w_wr_word;
    logic [255:0]           w_blk_rd;
    logic                   w_last;
    logic                   w_wr_done;
    logic                   w_unused_addr;

    assign w_line        = data_address_fCPU[LINE_BITS+4:5];
    assign w_word        = data_address_fCPU[4:2];
    assign w_off         = data_address_fCPU[1:0];
    assign w_widx        = {w_line, w_word};
    assign w_unused_addr = ^data_address_fCPU[31:LINE_BITS+5];

    assign w_rd_word      = r_mem[w_widx];
    assign data_read_2CPU = MemRead_fCPU ? w_rd_word : 32'd0;

    // Left-justify the N payload bytes, then slide them right to the byte offset;
    // anything pushed past byte 3 falls off the end of the word.
    assign w_nbytes  = (data_write_size_fCPU == 2'd0) ? 3'd4 : {1'b0, data_write_size_fCPU};
    assign w_data_al = (data_write_fCPU << (6'd32 - {w_nbytes, 3'b000})) >> {w_off, 3'b000};
    assign w_bmask   = (4'b1111 << (3'd4 - w_nbytes)) >> w_off;

    always_comb begin
        w_wr_word = w_rd_word;
        for (int k = 0; k < 4; k++) begin
            if (w_bmask[3-k]) begin
                w_wr_word[31-8*k -: 8] = w_data_al[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        w_blk_rd = '0;
        for (int i = 0; i < 8; i++) begin
            w_blk_rd[32*i +: 32] = r_mem[{r_line, 3'(i)}];
        end
    end

    assign w_last    = (r_cnt == 8'd0);
    assign w_wr_done = !RESET && (r_state == S_WR_WAIT) && dBlkWrite_fCPU && w_last;

    // Block commit is issued after the word write so it wins on the same line.
    always_ff @(posedge CLK) begin
        if (MemWrite_fCPU) begin
            r_mem[w_widx] <= w_wr_word;
        end
        if (w_wr_done) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[{r_line, 3'(i)}] <= r_blk_wdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state                <= S_IDLE;
            r_cnt                  <= 8'd0;
            block_read_2CPU        <= '0;
            block_read_valid_2CPU  <= 1'b0;
            block_write_valid_2CPU <= 1'b0;
            busy_2CPU              <= 1'b0;
        end else begin
            block_read_valid_2CPU  <= 1'b0;
            block_write_valid_2CPU <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dBlkWrite_fCPU) begin
                        r_line      <= w_line;
                        r_blk_wdata <= block_write_fCPU;
                        r_cnt       <= LAT_M1;
                        r_state     <= S_WR_WAIT;
                        busy_2CPU   <= 1'b1;
                    end else if (dBlkRead_fCPU) begin
                        r_line    <= w_line;
                        r_cnt     <= LAT_M1;
                        r_state   <= S_RD_WAIT;
                        busy_2CPU <= 1'b1;
                    end else begin
                        busy_2CPU <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (!dBlkRead_fCPU) begin
                        r_state   <= S_IDLE;
                        busy_2CPU <= 1'b0;
                    end else if (!w_last) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        block_read_2CPU       <= w_blk_rd;
                        block_read_valid_2CPU <= 1'b1;
                        r_state               <= S_DONE;
                    end
                end
                S_WR_WAIT: begin
                    if (!dBlkWrite_fCPU) begin
                        r_state   <= S_IDLE;
                        busy_2CPU <= 1'b0;
                    end else if (!w_last) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        block_write_valid_2CPU <= 1'b1;
                        r_state                <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Hold here until the requester lets go so a held level cannot re-trigger.
                    if (!dBlkRead_fCPU && !dBlkWrite_fCPU) begin
                        r_state   <= S_IDLE;
                        busy_2CPU <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    busy_2CPU <= 1'b0;
                end
            endcase
        end
    end

endmodule
